ins_decode: RTL and testbench
=============================

INS_DECODE -- requirements
Module: ins_decode

Interface
REQ-001 Parameter IMM_SIGNED, default 1: 1 = sign-extend imm6 to 16 bits, 0 = zero-extend.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream fetch presents a valid instruction.
REQ-005 instr  input  16  fetched instruction word.
REQ-006 pc_in  input  16  PC of instr.
REQ-007 in_ready  output  1  decode can accept instr this cycle.
REQ-008 out_ready  input  1  downstream execute accepts the held decode result.
REQ-009 flush  input  1  discard held and incoming instruction (branch redirect).
REQ-010 wb_en  input  1  register write-back enable.
REQ-011 wb_addr  input  3  write-back register index.
REQ-012 wb_data  input  16  write-back data.
REQ-013 out_valid  output  1  decoded fields valid.
REQ-014 opcode  output  4  instr[15:12] of held instruction.
REQ-015 rd  output  3  instr[11:9].
REQ-016 rs1_data  output  16  register file value of instr[8:6].
REQ-017 rs2_data  output  16  register file value of instr[5:3].
REQ-018 imm  output  16  instr[5:0] extended per IMM_SIGNED.
REQ-019 pc_out  output  16  PC of held instruction.

Function
REQ-020 The block SHALL contain an 8 x 16-bit register file; r0 SHALL always read 0 and SHALL ignore writes.
REQ-021 At posedge clk with wb_en=1 and wb_addr!=0, the register file SHALL store wb_data at wb_addr.
REQ-022 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-023 Capture: at posedge clk with in_valid && in_ready && !flush, all outputs SHALL load the decode of instr/pc_in and out_valid SHALL become 1; latency one cycle.
REQ-024 rs1_data/rs2_data SHALL be read from the register file at the capture edge and held unchanged while out_valid && !out_ready.
REQ-025 Drain: at posedge clk with out_valid && out_ready && !(in_valid) , out_valid SHALL become 0; data outputs SHALL hold their last values.
REQ-026 Back-to-back: out_ready=1 and in_valid=1 together SHALL replace the held instruction with the new one, out_valid staying 1, no bubble.
REQ-027 Stall: out_valid=1 and out_ready=0 SHALL hold all outputs and deassert in_ready; the upstream instr SHALL not be consumed.
REQ-028 flush=1 at posedge clk SHALL force out_valid to 0 and SHALL block capture that edge, regardless of in_valid/out_ready; write-back SHALL still occur.
REQ-029 imm with IMM_SIGNED=1: instr[5]=1 SHALL yield 16'hFFC0 | instr[5:0]; IMM_SIGNED=0: upper 10 bits zero.
REQ-030 Field extraction SHALL apply to every opcode; no opcode-specific filtering.

Reset
REQ-031 reset=0 SHALL immediately clear out_valid, opcode, rd, rs1_data, rs2_data, imm, pc_out and all eight registers to 0, independent of clk.
REQ-032 Reset asserted mid-stall SHALL discard the held instruction; after release in_ready SHALL be 1.
REQ-033 First capture SHALL occur no earlier than the first posedge clk after reset returns to 1.

Configuration
REQ-034 Macro DEC_BYPASS_EN defined: when capture and a write-back to a source register (non-zero index) coincide on the same edge, the captured rs1_data/rs2_data SHALL be wb_data.
REQ-035 DEC_BYPASS_EN undefined: the captured value SHALL be the register's pre-write contents; the write still completes.

Verification
REQ-036 Reset, write r3=16'h1234, then capture instr 16'h10C0 (rs1=r3), pc_in=5 -> next cycle out_valid=1, opcode=1, rs1_data=16'h1234, pc_out=5.
REQ-037 Capture instr with imm6=6'b111110, IMM_SIGNED=1 -> imm=16'hFFFE; IMM_SIGNED=0 -> imm=16'h003E.
REQ-038 Hold out_ready=0 for 3 cycles with new in_valid instr -> in_ready=0, outputs unchanged; out_ready=1 -> next instr captured next edge, out_valid stays 1.
REQ-039 Same edge: wb_en=1, wb_addr=2, wb_data=16'hBEEF and capture instr reading r2 (old 16'h0001) -> rs2/rs1 shows 16'hBEEF with DEC_BYPASS_EN, 16'h0001 without.
REQ-040 flush=1 with in_valid=1, out_valid=1 -> next cycle out_valid=0; write wb_addr=0 data 16'hFFFF -> subsequent r0 read is 0.
REQ-041 reset=0 pulse between clock edges during stall -> out_valid=0 and all registers 0 immediately, in_ready=1.

Source files
------------

// File: rtl/ins_decode.sv
// ---------------------------------------------------------------------------
// ins_decode -- single-entry instruction decode stage with register file
//
// Purpose:
//   Accepts one 16-bit instruction per cycle from fetch. It extracts
//   opcode/rd/imm, reads two source operands from an 8 x 16 register file
//   (r0 is hard-wired to zero) and holds the result for execute under a
//   valid/ready handshake. A flush discards the held and incoming
//   instruction. Register write-back is independent of the handshake and of
//   flush.
//
// Configuration:
//   IMM_SIGNED (param, default 1) : 1 sign-extends imm6, 0 zero-extends it.
//   `DEC_BYPASS_EN (macro)        : when defined, a write-back that lands on
//                                   a source register at the capture edge is
//                                   forwarded into rs1_data/rs2_data. When
//                                   undefined, the pre-write value is
//                                   captured.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   reset     in   asynchronous active-low reset
//   in_valid  in   fetch presents instr/pc_in
//   instr     in   [15:0] instruction word
//   pc_in     in   [15:0] PC of instr
//   in_ready  out  decode can take instr this cycle
//   out_ready in   execute accepts the held result
//   flush     in   discard held and incoming instruction
//   wb_en     in   register write-back enable
//   wb_addr   in   [2:0] write-back index (writes to r0 are dropped)
//   wb_data   in   [15:0] write-back data
//   out_valid out  decoded fields valid
//   opcode    out  [3:0]  instr[15:12]
//   rd        out  [2:0]  instr[11:9]
//   rs1_data  out  [15:0] register value of instr[8:6]
//   rs2_data  out  [15:0] register value of instr[5:3]
//   imm       out  [15:0] extended instr[5:0]
//   pc_out    out  [15:0] PC of held instruction
// ---------------------------------------------------------------------------
module ins_decode #(
  parameter int IMM_SIGNED = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] instr,
  input  logic [15:0] pc_in,
  output logic        in_ready,
  input  logic        out_ready,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        out_valid,
  output logic [3:0]  opcode,
  output logic [2:0]  rd,
  output logic [15:0] rs1_data,
  output logic [15:0] rs2_data,
  output logic [15:0] imm,
  output logic [15:0] pc_out
);

  // -------------------------------------------------------------------------
  // Register file: r1..r7 are real flops. r0 has no storage and reads zero.
  // Kept in flops rather than RAM because reset must clear every entry
  // asynchronously.
  // -------------------------------------------------------------------------
  logic [15:0] rf_q [1:7];
  logic [15:0] rf_d [1:7];

  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_rf_next
      assign rf_d[gi] = (wb_en && (wb_addr == 3'(gi))) ? wb_data : rf_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 8; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 1; i < 8; i++) rf_q[i] <= rf_d[i];
    end
  end

  // -------------------------------------------------------------------------
  // Source operand read (combinational, sampled into the output regs at the
  // capture edge).
  // -------------------------------------------------------------------------
  logic [2:0]  rs1_idx;
  logic [2:0]  rs2_idx;
  logic [15:0] rs1_raw;
  logic [15:0] rs2_raw;
  logic [15:0] rs1_sel;
  logic [15:0] rs2_sel;

  assign rs1_idx = instr[8:6];
  assign rs2_idx = instr[5:3];

  always_comb begin
    rs1_raw = '0;
    rs2_raw = '0;
    for (int i = 1; i < 8; i++) begin
      if (rs1_idx == 3'(i)) rs1_raw = rf_q[i];
      if (rs2_idx == 3'(i)) rs2_raw = rf_q[i];
    end
  end

`ifdef DEC_BYPASS_EN
  // Forward a same-edge write so the captured operand is the newest value.
  // r0 is excluded: its write is dropped, so it must still read zero.
  logic wb_hit1;
  logic wb_hit2;
  assign wb_hit1 = wb_en && (wb_addr != 3'd0) && (wb_addr == rs1_idx);
  assign wb_hit2 = wb_en && (wb_addr != 3'd0) && (wb_addr == rs2_idx);
  assign rs1_sel = wb_hit1 ? wb_data : rs1_raw;
  assign rs2_sel = wb_hit2 ? wb_data : rs2_raw;
`else
  assign rs1_sel = rs1_raw;
  assign rs2_sel = rs2_raw;
`endif

  // -------------------------------------------------------------------------
  // Immediate extension
  // -------------------------------------------------------------------------
  logic [15:0] imm_ext;
  assign imm_ext = (IMM_SIGNED != 0) ? {{10{instr[5]}}, instr[5:0]}
                                     : {10'd0, instr[5:0]};

  // -------------------------------------------------------------------------
  // Handshake and output stage
  // -------------------------------------------------------------------------
  logic        out_valid_q, out_valid_d;
  logic [3:0]  opcode_q,    opcode_d;
  logic [2:0]  rd_q,        rd_d;
  logic [15:0] rs1_q,       rs1_d;
  logic [15:0] rs2_q,       rs2_d;
  logic [15:0] imm_q,       imm_d;
  logic [15:0] pc_q,        pc_d;
  logic        capture;

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    pc_d        = pc_q;

    if (flush) begin
      // Flush wins over capture and drain. The data fields keep their last
      // values because nothing downstream looks at them while invalid.
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      opcode_d    = instr[15:12];
      rd_d        = instr[11:9];
      rs1_d       = rs1_sel;
      rs2_d       = rs2_sel;
      imm_d       = imm_ext;
      pc_d        = pc_in;
    end else if (out_ready) begin
      // Held result consumed with nothing new behind it.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign rd        = rd_q;
  assign rs1_data  = rs1_q;
  assign rs2_data  = rs2_q;
  assign imm       = imm_q;
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_ins_decode.sv
// ---------------------------------------------------------------------------
// tb_ins_decode -- directed self-checking bench for ins_decode.
// Two instances share every input: dut (IMM_SIGNED=1) is fully checked, and
// dut_z (IMM_SIGNED=0) is checked only for its zero-extended immediate.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ins_decode;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] instr;
  logic [15:0] pc_in;
  logic        out_ready;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  logic        in_ready;
  logic        out_valid;
  logic [3:0]  opcode;
  logic [2:0]  rd;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
  logic [15:0] imm;
  logic [15:0] pc_out;

  logic        z_in_ready;
  logic        z_out_valid;
  logic [3:0]  z_opcode;
  logic [2:0]  z_rd;
  logic [15:0] z_rs1_data;
  logic [15:0] z_rs2_data;
  logic [15:0] z_imm;
  logic [15:0] z_pc_out;

  int pass_cnt = 0;
  int tot_cnt  = 0;

`ifdef DEC_BYPASS_EN
  localparam logic [15:0] BYP_EXP = 16'hBEEF;
`else
  localparam logic [15:0] BYP_EXP = 16'h0001;
`endif

  ins_decode #(.IMM_SIGNED(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .pc_in(pc_in), .in_ready(in_ready), .out_ready(out_ready),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .opcode(opcode), .rd(rd), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm(imm), .pc_out(pc_out)
  );

  ins_decode #(.IMM_SIGNED(0)) dut_z (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .pc_in(pc_in), .in_ready(z_in_ready), .out_ready(out_ready),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(z_out_valid), .opcode(z_opcode), .rd(z_rd),
    .rs1_data(z_rs1_data), .rs2_data(z_rs2_data), .imm(z_imm),
    .pc_out(z_pc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 0; instr = '0; pc_in = '0; out_ready = 0; flush = 0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b0;
    #2;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %h exp 0", out_valid); else pass_cnt++;
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %h exp 1", in_ready); else pass_cnt++;
    tot_cnt++; if ({opcode, rd, rs1_data, rs2_data, imm, pc_out} !== '0) $display("FAIL reset_fields got %h exp 0", {opcode, rd, rs1_data, rs2_data, imm, pc_out}); else pass_cnt++;
    // Capture attempted while in reset must not happen.
    in_valid = 1; instr = 16'hF000; out_ready = 1;
    @(posedge clk); #1;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_no_capture got %h exp 0", out_valid); else pass_cnt++;
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_capture;
    wb_en = 1; wb_addr = 3'd3; wb_data = 16'h1234;
    tick();
    wb_en = 0;
    in_valid = 1; instr = 16'h10C0; pc_in = 16'd5; out_ready = 1;
    tick();
    in_valid = 0;
    $display("capture instr=10C0 pc=5 -> op=%h rs1=%h pc=%h", opcode, rs1_data, pc_out);
    tot_cnt++; if (out_valid !== 1'b1) $display("FAIL cap_out_valid got %h exp 1", out_valid); else pass_cnt++;
    tot_cnt++; if (opcode !== 4'h1) $display("FAIL cap_opcode got %h exp 1", opcode); else pass_cnt++;
    tot_cnt++; if (rs1_data !== 16'h1234) $display("FAIL cap_rs1 got %h exp 1234", rs1_data); else pass_cnt++;
    tot_cnt++; if (pc_out !== 16'd5) $display("FAIL cap_pc got %h exp 0005", pc_out); else pass_cnt++;
    tot_cnt++; if (rs2_data !== 16'h0000) $display("FAIL cap_rs2_r0 got %h exp 0000", rs2_data); else pass_cnt++;
    // Drain: valid drops, data holds.
    tick();
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL drain_out_valid got %h exp 0", out_valid); else pass_cnt++;
    tot_cnt++; if (pc_out !== 16'd5 || rs1_data !== 16'h1234) $display("FAIL drain_hold got pc=%h rs1=%h exp 0005/1234", pc_out, rs1_data); else pass_cnt++;
    out_ready = 0;
  endtask

  task automatic test_imm;
    in_valid = 1; instr = 16'h003E; pc_in = 16'd6; out_ready = 1;
    tick();
    in_valid = 0;
    $display("imm instr=003E -> signed=%h unsigned=%h", imm, z_imm);
    tot_cnt++; if (imm !== 16'hFFFE) $display("FAIL imm_signed got %h exp FFFE", imm); else pass_cnt++;
    tot_cnt++; if (z_imm !== 16'h003E) $display("FAIL imm_unsigned got %h exp 003E", z_imm); else pass_cnt++;
    tick();
    out_ready = 0;
  endtask

  task automatic test_stall;
    // Instruction A: opcode 2, rd 5, rs1 r1, rs2 r0, imm 5.
    in_valid = 1; instr = 16'h2A45; pc_in = 16'd10; out_ready = 0;
    tick();
    tot_cnt++; if (out_valid !== 1'b1 || rd !== 3'd5 || imm !== 16'd5) $display("FAIL stall_cap_a got v=%h rd=%h imm=%h exp 1/5/0005", out_valid, rd, imm); else pass_cnt++;
    instr = 16'h3000; pc_in = 16'd20;
    for (int c = 0; c < 3; c++) begin
      tot_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready cyc%0d got %h exp 0", c, in_ready); else pass_cnt++;
      tick();
      tot_cnt++; if (opcode !== 4'h2 || pc_out !== 16'd10 || out_valid !== 1'b1) $display("FAIL stall_hold cyc%0d got op=%h pc=%h v=%h exp 2/000a/1", c, opcode, pc_out, out_valid); else pass_cnt++;
    end
    out_ready = 1;
    #1;
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready got %h exp 1", in_ready); else pass_cnt++;
    tick();
    in_valid = 0;
    $display("back_to_back -> op=%h pc=%h v=%h", opcode, pc_out, out_valid);
    tot_cnt++; if (opcode !== 4'h3 || pc_out !== 16'd20 || out_valid !== 1'b1) $display("FAIL b2b_capture got op=%h pc=%h v=%h exp 3/0014/1", opcode, pc_out, out_valid); else pass_cnt++;
    tick();
    out_ready = 0;
  endtask

  task automatic test_bypass;
    wb_en = 1; wb_addr = 3'd2; wb_data = 16'h0001;
    tick();
    wb_data = 16'hBEEF;
    in_valid = 1; instr = 16'h4090; pc_in = 16'd30; out_ready = 1;
    tick();
    wb_en = 0;
    $display("bypass same edge -> rs1=%h rs2=%h", rs1_data, rs2_data);
    tot_cnt++; if (rs1_data !== BYP_EXP) $display("FAIL bypass_rs1 got %h exp %h", rs1_data, BYP_EXP); else pass_cnt++;
    tot_cnt++; if (rs2_data !== BYP_EXP) $display("FAIL bypass_rs2 got %h exp %h", rs2_data, BYP_EXP); else pass_cnt++;
    // The write itself must have completed either way.
    tick();
    in_valid = 0;
    tot_cnt++; if (rs1_data !== 16'hBEEF) $display("FAIL bypass_write_done got %h exp BEEF", rs1_data); else pass_cnt++;
    tick();
    out_ready = 0;
  endtask

  task automatic test_flush;
    in_valid = 1; instr = 16'h5000; pc_in = 16'd40; out_ready = 0;
    tick();
    tot_cnt++; if (out_valid !== 1'b1 || opcode !== 4'h5) $display("FAIL flush_pre got v=%h op=%h exp 1/5", out_valid, opcode); else pass_cnt++;
    instr = 16'h6000; pc_in = 16'd41; out_ready = 1; flush = 1;
    wb_en = 1; wb_addr = 3'd4; wb_data = 16'hAAAA;
    tick();
    flush = 0; in_valid = 0;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %h exp 0", out_valid); else pass_cnt++;
    tot_cnt++; if (opcode === 4'h6) $display("FAIL flush_blocked_capture got op=%h exp not 6", opcode); else pass_cnt++;
    wb_addr = 3'd0; wb_data = 16'hFFFF;
    tick();
    wb_en = 0;
    in_valid = 1; instr = 16'h7020; pc_in = 16'd42;
    tick();
    in_valid = 0;
    $display("after flush read r0/r4 -> rs1=%h rs2=%h", rs1_data, rs2_data);
    tot_cnt++; if (rs1_data !== 16'h0000) $display("FAIL r0_reads_zero got %h exp 0000", rs1_data); else pass_cnt++;
    tot_cnt++; if (rs2_data !== 16'hAAAA) $display("FAIL flush_wb_done got %h exp AAAA", rs2_data); else pass_cnt++;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset_mid_stall;
    in_valid = 1; instr = 16'h80C0; pc_in = 16'd50; out_ready = 0;
    tick();
    tot_cnt++; if (out_valid !== 1'b1 || rs1_data !== 16'h1234) $display("FAIL rst_stall_pre got v=%h rs1=%h exp 1/1234", out_valid, rs1_data); else pass_cnt++;
    instr = 16'h9000;
    #1;
    reset = 1'b0;
    #1;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_async_out_valid got %h exp 0", out_valid); else pass_cnt++;
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_async_in_ready got %h exp 1", in_ready); else pass_cnt++;
    tot_cnt++; if (rs1_data !== 16'h0000 || pc_out !== 16'h0000) $display("FAIL rst_async_fields got rs1=%h pc=%h exp 0/0", rs1_data, pc_out); else pass_cnt++;
    reset = 1'b1;
    // r3 and r4 held 1234/AAAA before reset; both must now read zero.
    instr = 16'h10E0; out_ready = 1;
    tick();
    in_valid = 0;
    $display("post reset read r3/r4 -> rs1=%h rs2=%h", rs1_data, rs2_data);
    tot_cnt++; if (rs1_data !== 16'h0000 || rs2_data !== 16'h0000) $display("FAIL rst_regs_cleared got rs1=%h rs2=%h exp 0/0", rs1_data, rs2_data); else pass_cnt++;
    tot_cnt++; if (out_valid !== 1'b1 || opcode !== 4'h1) $display("FAIL rst_post_capture got v=%h op=%h exp 1/1", out_valid, opcode); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_imm();
    test_stall();
    test_bypass();
    test_flush();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
